// File: rtl/filter_line_buf_pkg.sv
// Shared types and defaults for the PNG filter scanline neighbour buffer.
package filter_line_buf_pkg;

    localparam int WIDTH_MAX_DEF = 4096;
    localparam int DATA_WD_DEF   = 8;
    localparam int BPP_MAX_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    // Width of a byte counter able to hold the value n itself (not just n-1).
    function automatic int cnt_wd(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/filter_line_buf_ram.sv
// Single-port previous-row store; one address shared by the registered read and the write.
module filter_line_buf_ram #(
    parameter int SIZE    = 4096,
    parameter int DATA_WD = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [$clog2(SIZE)-1:0] adr,
    input  logic                    rd_val,
    input  logic                    wr_val,
    input  logic [DATA_WD-1:0]      wr_dat,
    output logic [DATA_WD-1:0]      rd_dat_o,
    output logic                    rd_val_o
);

    logic [DATA_WD-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
        if (wr_val) begin
            mem[adr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_dat_o <= '0;
            rd_val_o <= 1'b0;
        end else begin
            rd_val_o <= rd_val;
            if (rd_val) begin
                rd_dat_o <= mem[adr];
            end
        end
    end

endmodule

// File: rtl/filter_line_buf.sv
// Emits x/a/b/c PNG filter neighbours for every byte of the raw image stream.
//  state   | meaning
//  IDLE    | no valid config, input not accepted
//  ACC     | ready for a byte; a transfer issues the ram read of the old byte at col
//  WR      | old byte available; write new byte back, register outputs, advance col
module filter_line_buf
    import filter_line_buf_pkg::*;
#(
    parameter int WIDTH_MAX = WIDTH_MAX_DEF,
    parameter int DATA_WD   = DATA_WD_DEF,
    parameter int BPP_MAX   = BPP_MAX_DEF
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start_i,
    input  logic [cnt_wd(WIDTH_MAX)-1:0]  row_len_i,
    input  logic [3:0]                    bpp_i,
    input  logic                          dat_val_i,
    input  logic [DATA_WD-1:0]            dat_i,
    output logic                          dat_rdy_o,
    output logic                          val_o,
    output logic [DATA_WD-1:0]            x_o,
    output logic [DATA_WD-1:0]            a_o,
    output logic [DATA_WD-1:0]            b_o,
    output logic [DATA_WD-1:0]            c_o,
    output logic                          sol_o,
    output logic                          eol_o
);

    localparam int AW = $clog2(WIDTH_MAX);
    localparam int CW = cnt_wd(WIDTH_MAX);
    localparam int HW = $clog2(BPP_MAX);

    state_t             state;
    logic [AW-1:0]      col;
    logic               first_row;
    logic [CW-1:0]      row_len_r;
    logic [HW-1:0]      bpp_m1;
    logic [DATA_WD-1:0] x_r;
    logic [DATA_WD-1:0] x_hist [BPP_MAX];
    logic [DATA_WD-1:0] b_hist [BPP_MAX];

    logic               ram_rd_val;
    logic               ram_wr_val;
    logic [DATA_WD-1:0] ram_rd_dat;
    logic               ram_rd_ok;

    logic [CW-1:0]      row_len_sat;
    logic [3:0]         bpp_sat;
    logic [DATA_WD-1:0] b_cur;
    logic [DATA_WD-1:0] a_cur;
    logic [DATA_WD-1:0] c_cur;
    logic               col_lt_bpp;
    logic               last_col;

    // start_i wins over a same-cycle transfer or a pending write-back.
    assign dat_rdy_o  = (state == ST_ACC);
    assign ram_rd_val = dat_rdy_o && dat_val_i && !start_i;
    assign ram_wr_val = (state == ST_WR) && !start_i;

    assign b_cur      = (ram_rd_ok && !first_row) ? ram_rd_dat : '0;
    assign col_lt_bpp = ({1'b0, col} <= CW'(bpp_m1));
    assign a_cur      = col_lt_bpp ? '0 : x_hist[bpp_m1];
    assign c_cur      = col_lt_bpp ? '0 : b_hist[bpp_m1];
    assign last_col   = ({1'b0, col} == (row_len_r - CW'(1)));

    always_comb begin
        row_len_sat = row_len_i;
        if (row_len_i > CW'(WIDTH_MAX)) begin
            row_len_sat = CW'(WIDTH_MAX);
        end
        bpp_sat = bpp_i;
        if (bpp_i == 4'd0) begin
            bpp_sat = 4'd1;
        end else if (bpp_i > 4'(BPP_MAX)) begin
            bpp_sat = 4'(BPP_MAX);
        end
    end

    filter_line_buf_ram #(
        .SIZE    (WIDTH_MAX),
        .DATA_WD (DATA_WD)
    ) u_ram (
        .clk      (clk),
        .rstn     (rstn),
        .adr      (col),
        .rd_val   (ram_rd_val),
        .wr_val   (ram_wr_val),
        .wr_dat   (x_r),
        .rd_dat_o (ram_rd_dat),
        .rd_val_o (ram_rd_ok)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            col       <= '0;
            first_row <= 1'b1;
            row_len_r <= '0;
            bpp_m1    <= '0;
            x_r       <= '0;
            val_o     <= 1'b0;
            x_o       <= '0;
            a_o       <= '0;
            b_o       <= '0;
            c_o       <= '0;
            sol_o     <= 1'b0;
            eol_o     <= 1'b0;
            for (int i = 0; i < BPP_MAX; i++) begin
                x_hist[i] <= '0;
                b_hist[i] <= '0;
            end
        end else if (start_i) begin
            col       <= '0;
            first_row <= 1'b1;
            row_len_r <= row_len_sat;
            bpp_m1    <= HW'(bpp_sat - 4'd1);
            val_o     <= 1'b0;
            state     <= (row_len_i == '0) ? ST_IDLE : ST_ACC;
        end else begin
            val_o <= 1'b0;
            case (state)
                ST_IDLE: state <= ST_IDLE;
                ST_ACC: begin
                    if (dat_val_i) begin
                        x_r   <= dat_i;
                        state <= ST_WR;
                    end
                end
                ST_WR: begin
                    val_o <= 1'b1;
                    x_o   <= x_r;
                    a_o   <= a_cur;
                    b_o   <= b_cur;
                    c_o   <= c_cur;
                    sol_o <= (col == '0);
                    eol_o <= last_col;
                    for (int i = BPP_MAX - 1; i > 0; i--) begin
                        x_hist[i] <= x_hist[i-1];
                        b_hist[i] <= b_hist[i-1];
                    end
                    x_hist[0] <= x_r;
                    b_hist[0] <= b_cur;
                    if (last_col) begin
                        col       <= '0;
                        first_row <= 1'b0;
                    end else begin
                        col <= col + AW'(1);
                    end
                    state <= ST_ACC;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_line_buf.sv
// Scoreboard bench for filter_line_buf: directed rows, restart mid-row, config clamping, async reset.
module tb_filter_line_buf;

    localparam int WIDTH_MAX = 4096;
    localparam int DATA_WD   = 8;
    localparam int BPP_MAX   = 8;
    localparam int CW        = $clog2(WIDTH_MAX) + 1;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               start = 1'b0;
    logic [CW-1:0]      row_len = '0;
    logic [3:0]         bpp = '0;
    logic               dat_val = 1'b0;
    logic [DATA_WD-1:0] dat = '0;
    logic               dat_rdy;
    logic               val;
    logic [DATA_WD-1:0] x, a, b, c;
    logic               sol, eol;

    filter_line_buf #(
        .WIDTH_MAX (WIDTH_MAX),
        .DATA_WD   (DATA_WD),
        .BPP_MAX   (BPP_MAX)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start_i   (start),
        .row_len_i (row_len),
        .bpp_i     (bpp),
        .dat_val_i (dat_val),
        .dat_i     (dat),
        .dat_rdy_o (dat_rdy),
        .val_o     (val),
        .x_o       (x),
        .a_o       (a),
        .b_o       (b),
        .c_o       (c),
        .sol_o     (sol),
        .eol_o     (eol)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] x, a, b, c;
        logic       sol, eol;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   xfer_cyc;
    int   vx[8], va[8], vb[8], vc[8];

    // Monitor: every val_o pulse must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        exp_t e, got;
        if (rstn && val) begin
            checks++;
            got = '{x, a, b, c, sol, eol, cyc};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_val got x=%0d a=%0d b=%0d c=%0d sol=%0d eol=%0d cyc=%0d",
                         x, a, b, c, sol, eol, cyc);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL nbr got x=%0d a=%0d b=%0d c=%0d sol=%0d eol=%0d cyc=%0d want x=%0d a=%0d b=%0d c=%0d sol=%0d eol=%0d cyc=%0d",
                             got.x, got.a, got.b, got.c, got.sol, got.eol, got.cyc,
                             e.x, e.a, e.b, e.c, e.sol, e.eol, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    function automatic exp_t mk(input int ex, input int ea, input int eb, input int ec,
                                input bit es, input bit ee);
        exp_t e;
        e.x   = ex[7:0];
        e.a   = ea[7:0];
        e.b   = eb[7:0];
        e.c   = ec[7:0];
        e.sol = es;
        e.eol = ee;
        e.cyc = 0;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input int d, input exp_t e, input bit hold);
        int budget = 0;
        dat_val = 1'b1;
        dat     = d[7:0];
        while (!dat_rdy && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!dat_rdy) begin
            chk("rdy_timeout", 0, 1);
            dat_val = 1'b0;
            return;
        end
        e.cyc    = cyc + 2;
        xfer_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        if (!hold) dat_val = 1'b0;
    endtask

    task automatic do_start(input int len, input int bp);
        start   = 1'b1;
        row_len = len[CW-1:0];
        bpp     = bp[3:0];
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic run_row(input int n, input bit hold);
        int prev = 0;
        for (int i = 0; i < n; i++) begin
            send(vx[i], mk(vx[i], va[i], vb[i], vc[i], i == 0, i == n - 1), hold);
            if (hold && i > 0) chk("xfer_gap", xfer_cyc - prev, 2);
            prev = xfer_cyc;
        end
        dat_val = 1'b0;
        drain();
    endtask

    initial begin
        // Reset and idle behaviour
        repeat (3) begin
            @(negedge clk);
            dat_val = 1'($urandom);
        end
        chk("rst_rdy", dat_rdy, 0);
        chk("rst_val", val, 0);
        chk("rst_data", {x, a, b, c}, 0);
        chk("rst_flags", {sol, eol}, 0);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dat_val = 1'($urandom);
            chk("idle_rdy", dat_rdy, 0);
            chk("idle_wr", dut.ram_wr_val, 0);
        end
        dat_val = 1'b0;

        // Row length 4, one byte per pixel
        do_start(4, 1);
        vx = '{1, 2, 3, 4, 0, 0, 0, 0};
        va = '{0, 1, 2, 3, 0, 0, 0, 0};
        vb = '{0, 0, 0, 0, 0, 0, 0, 0};
        vc = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_row(4, 1'b0);
        vx = '{5, 6, 7, 8, 0, 0, 0, 0};
        va = '{0, 5, 6, 7, 0, 0, 0, 0};
        vb = '{1, 2, 3, 4, 0, 0, 0, 0};
        vc = '{0, 1, 2, 3, 0, 0, 0, 0};
        run_row(4, 1'b1);

        // Row length 6, three bytes per pixel
        do_start(6, 3);
        vx = '{10, 11, 12, 13, 14, 15, 0, 0};
        va = '{0, 0, 0, 10, 11, 12, 0, 0};
        vb = '{0, 0, 0, 0, 0, 0, 0, 0};
        vc = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_row(6, 1'b1);
        vx = '{20, 21, 22, 23, 24, 25, 0, 0};
        va = '{0, 0, 0, 20, 21, 22, 0, 0};
        vb = '{10, 11, 12, 13, 14, 15, 0, 0};
        vc = '{0, 0, 0, 10, 11, 12, 0, 0};
        run_row(6, 1'b1);

        // Restart during the write-back of a byte: that byte must vanish
        do_start(4, 2);
        vx = '{30, 31, 32, 33, 0, 0, 0, 0};
        va = '{0, 0, 30, 31, 0, 0, 0, 0};
        vb = '{0, 0, 0, 0, 0, 0, 0, 0};
        vc = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_row(4, 1'b0);
        send(40, mk(40, 0, 30, 0, 1'b1, 1'b0), 1'b0);
        send(41, mk(41, 0, 31, 0, 1'b0, 1'b0), 1'b0);
        drain();
        dat_val = 1'b1;
        dat     = 8'd42;
        begin
            int budget = 0;
            while (!dat_rdy && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            chk("drop_rdy", dat_rdy, 1);
        end
        @(negedge clk);
        dat_val = 1'b0;
        chk("drop_in_wr", dat_rdy, 0);
        do_start(4, 1);
        send(99, mk(99, 0, 0, 0, 1'b1, 1'b0), 1'b0);
        drain();

        // Zero row length keeps the block idle
        do_start(0, 1);
        dat_val = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("len0_rdy", dat_rdy, 0);
        end
        dat_val = 1'b0;

        // Oversized row length saturates; bpp 0 behaves as 1
        do_start(WIDTH_MAX + 5, 0);
        for (int i = 0; i < WIDTH_MAX; i++) begin
            send((i + 1) & 255, mk((i + 1) & 255, (i == 0) ? 0 : (i & 255), 0, 0,
                                   i == 0, i == WIDTH_MAX - 1), 1'b1);
        end
        send(8'h77, mk(8'h77, 0, 1, 0, 1'b1, 1'b0), 1'b0);
        drain();

        // Asynchronous reset in the middle of a row
        do_start(4, 1);
        send(1, mk(1, 0, 0, 0, 1'b1, 1'b0), 1'b1);
        send(2, mk(2, 1, 0, 0, 1'b0, 1'b0), 1'b0);
        chk("pre_rst_x", x, 1);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_rdy", dat_rdy, 0);
        chk("async_rst_val", val, 0);
        chk("async_rst_data", {x, a, b, c}, 0);
        chk("async_rst_flags", {sol, eol}, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_rdy", dat_rdy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
